// File: rtl/router_out_fifo.sv
// Per-port output buffer of the 1x3 router: DEPTH x 9-bit FIFO with header tracking.
// Latency: write visible on valid_out right after the accepting edge; data_out registered, updated at the read edge.
// Backpressure: writes are dropped while full; reads are ignored while empty; soft_reset flushes everything.
module router_out_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             full,
  output logic             pkt_active
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PKT_W = 7;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage: bit WIDTH is the header marker, low bits are the byte.
  logic [WIDTH:0]       mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PKT_W-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0]     data_out_q, data_out_d;
  // Set for one cycle after the final byte of a packet leaves; triggers data_out clear.
  logic                 last_q, last_d;

  logic                 wr_acc;
  logic                 rd_acc;
  logic [WIDTH:0]       rd_word;

  assign full       = (cnt_q == FULL_CNT);
  assign valid_out  = (cnt_q != '0);
  assign pkt_active = (pkt_cnt_q != '0);
  assign data_out   = data_out_q;
  assign rd_word    = mem_q[rd_ptr_q];

  // Accept decisions; a soft reset cycle discards both requests.
  always_comb begin
    wr_acc = write_enb && !full && !soft_reset;
    rd_acc = read_enb && valid_out && !soft_reset;
  end

  // Next-state for pointers, occupancy, packet counter and read data.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;
    last_d     = 1'b0;

    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      pkt_cnt_d  = '0;
      data_out_d = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        data_out_d = rd_word[WIDTH-1:0];
        if (rd_word[WIDTH]) begin
          // Header carries payload length in [7:2]; +1 accounts for the parity byte.
          pkt_cnt_d = PKT_W'(rd_word[WIDTH-1:2]) + PKT_W'(1);
        end else if (pkt_cnt_q != '0) begin
          pkt_cnt_d = pkt_cnt_q - PKT_W'(1);
          last_d    = (pkt_cnt_q == PKT_W'(1));
        end
      end else if (last_q) begin
        data_out_d = '0;
      end

      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
      last_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
      last_q     <= last_d;
    end
  end

  // Memory array write; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= {lfd_state, data_in};
    end
  end

endmodule

// File: tb/tb_router_out_fifo.sv
module tb_router_out_fifo;

  logic       clock = 1'b0;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       valid_out;
  logic       full;
  logic       pkt_active;

  router_out_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .full       (full),
    .pkt_active (pkt_active)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of stored words plus packet bookkeeping.
  logic [8:0] q[$];
  int         pc;
  logic [7:0] dout;
  bit         last;
  bit         seen_full;

  logic [7:0] pkt_seq [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h3F};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    pc   = 0;
    dout = 8'h00;
    last = 1'b0;
  endtask

  // One clock: drive at negedge, model at posedge, compare at the following negedge.
  task automatic cyc(input bit we, input bit lfd, input logic [7:0] d, input bit re, input bit sr);
    bit         wa;
    bit         ra;
    bit         nl;
    logic [8:0] w;
    write_enb  = we;
    lfd_state  = lfd;
    data_in    = d;
    read_enb   = re;
    soft_reset = sr;
    @(posedge clock);
    if (sr) begin
      model_clear();
    end else begin
      wa = we && (q.size() < 16);
      ra = re && (q.size() > 0);
      nl = 1'b0;
      if (ra) begin
        w    = q.pop_front();
        dout = w[7:0];
        if (w[8]) begin
          pc = int'(w[7:2]) + 1;
        end else if (pc > 0) begin
          nl = (pc == 1);
          pc = pc - 1;
        end
      end else if (last) begin
        dout = 8'h00;
      end
      last = nl;
      if (wa) q.push_back({lfd, d});
    end
    @(negedge clock);
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    soft_reset = 1'b0;
    lfd_state  = 1'b0;
    if (full) seen_full = 1'b1;
    chk("valid_out", valid_out, q.size() != 0);
    chk("full", full, q.size() == 16);
    chk("pkt_active", pkt_active, pc != 0);
    chk("data_out", data_out, dout);
  endtask

  initial begin
    resetn     = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    read_enb   = 1'b0;
    seen_full  = 1'b0;
    model_clear();
    repeat (2) @(negedge clock);
    chk("rst_valid", valid_out, 0);
    chk("rst_full", full, 0);
    chk("rst_pkt_active", pkt_active, 0);
    chk("rst_data_out", data_out, 0);
    resetn = 1'b1;
    @(negedge clock);

    // Asynchronous reset mid-stream: outputs clear before any clock edge.
    cyc(1, 1, 8'h08, 0, 0);
    cyc(1, 0, 8'h55, 0, 0);
    cyc(1, 0, 8'h66, 1, 0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", valid_out, 0);
    chk("arst_full", full, 0);
    chk("arst_pkt_active", pkt_active, 0);
    chk("arst_data_out", data_out, 0);
    model_clear();
    @(negedge clock);
    resetn = 1'b1;
    cyc(1, 0, 8'hAA, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    chk("post_rst_read", data_out, 8'hAA);

    // Single packet: header 0D (length 3), three payload bytes, parity.
    for (int i = 0; i < 5; i++) cyc(1, i == 0, pkt_seq[i], 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 8'h00, 1, 0);
      chk("pkt_seq", data_out, pkt_seq[i]);
      chk("pkt_active_seq", pkt_active, i < 4);
    end
    cyc(0, 0, 8'h00, 0, 0);
    chk("pkt_clear", data_out, 8'h00);

    // Fill to full; the 17th word is dropped.
    for (int i = 0; i < 17; i++) begin
      cyc(1, 0, 8'(8'h40 + i), 0, 0);
      if (i == 15) chk("full_at_16", full, 1);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 8'h00, 1, 0);
      chk("fill_order", data_out, 8'(8'h40 + i));
    end
    chk("fill_empty", valid_out, 0);

    // Simultaneous read/write when full: read only, 15 words remain.
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h80 + i), 0, 0);
    cyc(1, 0, 8'hEE, 1, 0);
    chk("full_rw_full", full, 0);
    chk("full_rw_data", data_out, 8'h80);
    for (int i = 0; i < 15; i++) cyc(0, 0, 8'h00, 1, 0);
    chk("full_rw_last", data_out, 8'h8F);
    chk("full_rw_empty", valid_out, 0);

    // Simultaneous read/write with 8 words held: occupancy stays 8.
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'hC0 + i), 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 8'(8'hD0 + i), 1, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 8'h00, 1, 0);
    chk("mid_rw_remaining", valid_out, 1);
    cyc(0, 0, 8'h00, 1, 0);
    chk("mid_rw_last", data_out, 8'hD9);
    chk("mid_rw_empty", valid_out, 0);

    // Soft reset mid-packet together with a write.
    cyc(1, 1, 8'h14, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'(8'h21 + i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1, 0);
    chk("sr_pre_active", pkt_active, 1);
    cyc(1, 0, 8'h99, 0, 1);
    chk("sr_valid", valid_out, 0);
    chk("sr_pkt_active", pkt_active, 0);
    chk("sr_data_out", data_out, 8'h00);
    cyc(0, 0, 8'h00, 0, 0);
    chk("sr_write_dropped", valid_out, 0);

    // Wrap-around stream of 40 words with a 2-cycle read lag.
    seen_full = 1'b0;
    for (int i = 0; i < 42; i++) cyc(i < 40, 0, 8'(i * 7 + 3), i >= 2, 0);
    chk("wrap_never_full", seen_full, 0);
    chk("wrap_last", data_out, 8'(39 * 7 + 3));
    chk("wrap_empty", valid_out, 0);

    // Randomized traffic with occasional headers and soft resets.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 8'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_out_fifo.md
# router_out_fifo

Per-port output buffer of the 1x3 router. One instance per destination port: it stores 9-bit words (8 data bits plus a header marker) written by the router register stage, and drains them to the destination interface under `read_enb`. It presents `valid_out` and `data_out` to the destination side. It tracks packet length so the destination can tell when the final (parity) byte has left.

## Interface
- `DEPTH`, 16: number of 9-bit words stored; power of two.
- `WIDTH`, 8: data byte width.
- `clock`  in  1  single clock; all state changes on posedge.
- `resetn`  in  1  asynchronous, active-low reset.
- `soft_reset`  in  1  synchronous flush from the router synchronizer timeout; active-high.
- `write_enb`  in  1  write request from the router register stage.
- `lfd_state`  in  1  marks the word being written as a packet header; stored as bit 8.
- `data_in`  in  8  byte to write.
- `read_enb`  in  1  read request from the destination side.
- `data_out`  out  8  registered read data.
- `valid_out`  out  1  FIFO non-empty (combinational: occupancy != 0).
- `full`  out  1  occupancy == DEPTH.
- `pkt_active`  out  1  payload/parity bytes of the current packet still remain to be read.

## Operation
- Storage is DEPTH x 9 memory with 4-bit write and read pointers that wrap modulo DEPTH. A 5-bit occupancy counter runs from 0 to 16.
- Write accepted iff `write_enb && !full`. The memory location at the write pointer gets `{lfd_state, data_in}`, and the write pointer increments.
- Read accepted iff `read_enb && valid_out`. `data_out` gets `mem[rd_ptr][7:0]` and the read pointer increments.
- Read with the FIFO empty: `data_out` holds its value and pointers are unchanged.
- Occupancy changes by +1 on write only, -1 on read only, and stays unchanged on both or neither.
- Simultaneous read and write when full: only the read is accepted, because full blocks the write that cycle. The next cycle then has 15 words and `full` = 0.
- Simultaneous read and write when empty: only the write is accepted.
- Packet counter `pkt_cnt` is 7 bits:
  - Accepted read of a header word (bit 8 = 1) loads `pkt_cnt` = `mem[rd_ptr][7:2] + 1`, which is payload length plus the parity byte.
  - Accepted read of a non-header word decrements `pkt_cnt` if it is nonzero.
  - `pkt_active` = (`pkt_cnt` != 0).
- After the final byte of a packet is read (`pkt_cnt` reaches 0), `data_out` is cleared to 8'h00 on the next clock unless another read is accepted that cycle.
- `soft_reset`, when sampled high, does the following:
  - clears both pointers, occupancy, `pkt_cnt` and `data_out`;
  - discards any write or read in that same cycle.

## Timing
- `resetn` low asynchronously sets: pointers = 0, occupancy = 0, `pkt_cnt` = 0, `data_out` = 8'h00, `valid_out` = 0, `full` = 0, `pkt_active` = 0. Memory contents are not reset.
- Write latency: a write accepted at edge N makes `valid_out` high immediately after edge N.
- Read latency: a read accepted at edge M updates `data_out` immediately after edge M. The destination monitor samples it at edge M+1.
- `full` and `valid_out` derive from the registered occupancy, so they never glitch within a cycle.
- Pointer wrap: after location 15 the pointer goes to 0 with no bubble, and 32 consecutive writes and reads stream continuously.
- Throughput: one write and one read per cycle.
- Soft reset takes effect at the sampling edge, so `valid_out` = 0 directly after it.

## Test plan
- **Reset:** assert `resetn`=0 mid-stream.
  - Required response: all outputs 0 immediately, before any clock edge.
  - After release, a write of 8'hAA then a read gives `data_out`=8'hAA.
- **Single packet:**
  - Stimulus: write header 8'h0D (length 3, addr 1) with `lfd_state`=1, then 8'h11, 8'h22, 8'h33 and parity 8'h3F. Read all five words.
  - Required response: `data_out` sequence 0D,11,22,33,3F.
  - `pkt_active` goes high after the header read and drops after 3F.
  - `data_out`=00 one clock later.
- **Fill to full:** write 17 words with no reads.
  - Required response: `full`=1 after the 16th write; the 17th word is dropped.
  - Reading 16 words returns the first 16 in order, then `valid_out`=0.
- **Simultaneous events:**
  - When full: `write_enb` and `read_enb` together produce a read only, leaving occupancy 15.
  - When holding 8 words: both together keep occupancy at 8 and data order is intact.
- **Soft reset mid-packet:** after a header plus 2 bytes are read, pulse `soft_reset` together with a write.
  - Required response: `valid_out`=0, `pkt_active`=0, `data_out`=00, and the write is discarded.
- **Wrap-around:** stream 40 words with a 2-cycle read lag.
  - Required response: no loss and no reorder, and `full` never asserts.
